// File: rtl/sobel_window_ctrl_if.sv
// Pixel-stream and line-buffer control bundle for the 3x3 Sobel window sequencer.
// The slave side is the sequencer; the master side is the pixel source and datapath.
interface sobel_window_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 13
) ();
    logic              pix_valid;
    logic              sof;
    logic [2:0]        row_we;
    logic [ADDR_W-1:0] wr_adr;
    logic [ADDR_W-1:0] rd_adr;
    logic              shift_en;
    logic [CNT_W-1:0]  col;
    logic [CNT_W-1:0]  row;
    logic              win_valid;
    logic              line_done;
    logic              frame_done;
    logic [1:0]        state;

    modport slave (
        input  pix_valid, sof,
        output row_we, wr_adr, rd_adr, shift_en, col, row,
               win_valid, line_done, frame_done, state
    );

    modport master (
        output pix_valid, sof,
        input  row_we, wr_adr, rd_adr, shift_en, col, row,
               win_valid, line_done, frame_done, state
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Sequencer for the 3x3 Sobel window: tracks pixel position and drives line-buffer
// write enables, addresses and the window shift enable, all registered one cycle after acceptance.
module sobel_window_ctrl #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    sobel_window_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  nxt_col_q, nxt_col_d, nxt_row_q, nxt_row_d;
    logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
    logic [2:0]        row_we_q, row_we_d;
    logic [ADDR_W-1:0] wr_adr_q, wr_adr_d, rd_adr_q, rd_adr_d;
    logic              shift_en_q, shift_en_d;
    logic              win_valid_q, win_valid_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;

    logic              accept, resync, eol, eof;
    logic [CNT_W-1:0]  pix_col, pix_row;

    // A sof pixel is always (0,0), regardless of where the counters were.
    assign resync  = bus.pix_valid && bus.sof;
    assign accept  = bus.pix_valid && (bus.sof || (state_q != IDLE));
    assign pix_col = resync ? '0 : nxt_col_q;
    assign pix_row = resync ? '0 : nxt_row_q;
    assign eol     = accept && !resync && (pix_col == LAST_COL);
    assign eof     = eol && (pix_row == LAST_ROW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = FILL;
        end else if (accept) begin
            if (eof) begin
                state_d = IDLE;
            end else if ((state_q == FILL) && eol && (pix_row == ONE)) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        nxt_col_d    = nxt_col_q;
        nxt_row_d    = nxt_row_q;
        col_d        = col_q;
        row_d        = row_q;
        wr_adr_d     = wr_adr_q;
        rd_adr_d     = rd_adr_q;
        row_we_d     = 3'b000;
        shift_en_d   = 1'b0;
        win_valid_d  = 1'b0;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        if (accept) begin
            col_d        = pix_col;
            row_d        = pix_row;
            shift_en_d   = 1'b1;
            wr_adr_d     = ADDR_W'(pix_col);
            // Prefetch next column so the 1-cycle RAM read lines up with the next pixel.
            rd_adr_d     = (pix_col == LAST_COL) ? '0 : ADDR_W'(pix_col + ONE);
            row_we_d     = {pix_row >= TWO, pix_row >= ONE, 1'b1};
            win_valid_d  = (state_q == RUN) && !resync && (pix_row >= TWO) && (pix_col >= TWO);
            line_done_d  = eol;
            frame_done_d = eof;
            nxt_col_d    = eol ? '0 : pix_col + ONE;
            nxt_row_d    = eof ? '0 : (eol ? pix_row + ONE : pix_row);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_col_q    <= '0;
            nxt_row_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            wr_adr_q     <= '0;
            rd_adr_q     <= '0;
            row_we_q     <= 3'b000;
            shift_en_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            nxt_col_q    <= nxt_col_d;
            nxt_row_q    <= nxt_row_d;
            col_q        <= col_d;
            row_q        <= row_d;
            wr_adr_q     <= wr_adr_d;
            rd_adr_q     <= rd_adr_d;
            row_we_q     <= row_we_d;
            shift_en_q   <= shift_en_d;
            win_valid_q  <= win_valid_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.row_we     = row_we_q;
    assign bus.wr_adr     = wr_adr_q;
    assign bus.rd_adr     = rd_adr_q;
    assign bus.shift_en   = shift_en_q;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.line_done  = line_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl on an 8x6 frame: constant vector table, directed
// corner sequences and random traffic against a linear-pixel-index reference model.
module tb_sobel_window_ctrl;
    localparam int W      = 8;
    localparam int H      = 6;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_window_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       pv, sof, r;
        logic [2:0] we;
        logic       sh;
        int         wr, rd, col, row, st;
        logic       win, ld, fd;
    } vec_t;

    int ncmp = 0;
    int nmis = 0;
    int win_cnt = 0;
    int fd_cnt = 0;

    // Reference model: a frame is a run of W*H pixels indexed linearly from the last sof.
    int         m_p = 0;
    bit         m_in = 0;
    logic [2:0] e_we;
    logic       e_sh, e_win, e_ld, e_fd;
    int         e_wr, e_rd, e_col, e_row, e_st;

    task automatic model(input logic pv, input logic sf, input logic r);
        int  rr, cc;
        bit  last;
        e_we = 3'b000; e_sh = 1'b0; e_win = 1'b0; e_ld = 1'b0; e_fd = 1'b0;
        if (r) begin
            m_p = 0; m_in = 0;
            e_wr = 0; e_rd = 0; e_col = 0; e_row = 0; e_st = 0;
            return;
        end
        if (pv && (sf || m_in)) begin
            if (sf) m_p = 0;
            rr    = m_p / W;
            cc    = m_p % W;
            last  = (m_p == W * H - 1);
            e_we  = {rr >= 2, rr >= 1, 1'b1};
            e_sh  = 1'b1;
            e_wr  = cc;
            e_rd  = (cc + 1) % W;
            e_col = cc;
            e_row = rr;
            e_win = (rr >= 2) && (cc >= 2);
            e_ld  = (cc == W - 1);
            e_fd  = last;
            e_st  = last ? 0 : ((m_p + 1 >= 2 * W) ? 2 : 1);
            m_in  = !last;
            m_p   = last ? 0 : m_p + 1;
        end
    endtask

    function automatic logic [72:0] pack(input logic [2:0] we, input logic sh, input int wr,
                                         input int rd, input int c, input int rw, input int st,
                                         input logic win, input logic ld, input logic fd);
        return {we, sh, 16'(wr), 16'(rd), 16'(c), 16'(rw), 2'(st), win, ld, fd};
    endfunction

    function automatic logic [72:0] actual();
        return pack(bus.row_we, bus.shift_en, int'(bus.wr_adr), int'(bus.rd_adr), int'(bus.col),
                    int'(bus.row), int'(bus.state), bus.win_valid, bus.line_done, bus.frame_done);
    endfunction

    task automatic compare(input string name, input logic [72:0] act, input logic [72:0] exp);
        ncmp++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at %0t: got %h expected %h (we,sh,wr,rd,col,row,st,win,ld,fd)",
                     name, $time, act, exp);
        end
    endtask

    task automatic step(input logic pv, input logic sf, input logic r);
        bus.pix_valid = pv;
        bus.sof       = sf;
        rst           = r;
        @(posedge clk);
        #1;
        model(pv, sf, r);
        compare("model", actual(),
                pack(e_we, e_sh, e_wr, e_rd, e_col, e_row, e_st, e_win, e_ld, e_fd));
        if (bus.win_valid === 1'b1) win_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    vec_t tbl[10];

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;

        //          pv  sof r   we      sh  wr rd col row st win ld fd
        tbl[0] = '{1'b0,1'b0,1'b1, 3'b000,1'b0, 0, 0, 0, 0, 0, 1'b0,1'b0,1'b0};
        tbl[1] = '{1'b1,1'b0,1'b0, 3'b000,1'b0, 0, 0, 0, 0, 0, 1'b0,1'b0,1'b0};
        tbl[2] = '{1'b1,1'b1,1'b0, 3'b001,1'b1, 0, 1, 0, 0, 1, 1'b0,1'b0,1'b0};
        tbl[3] = '{1'b0,1'b0,1'b0, 3'b000,1'b0, 0, 1, 0, 0, 1, 1'b0,1'b0,1'b0};
        tbl[4] = '{1'b1,1'b0,1'b0, 3'b001,1'b1, 1, 2, 1, 0, 1, 1'b0,1'b0,1'b0};
        tbl[5] = '{1'b1,1'b1,1'b0, 3'b001,1'b1, 0, 1, 0, 0, 1, 1'b0,1'b0,1'b0};
        tbl[6] = '{1'b1,1'b0,1'b0, 3'b001,1'b1, 1, 2, 1, 0, 1, 1'b0,1'b0,1'b0};
        tbl[7] = '{1'b0,1'b0,1'b1, 3'b000,1'b0, 0, 0, 0, 0, 0, 1'b0,1'b0,1'b0};
        tbl[8] = '{1'b1,1'b0,1'b0, 3'b000,1'b0, 0, 0, 0, 0, 0, 1'b0,1'b0,1'b0};
        tbl[9] = '{1'b0,1'b1,1'b0, 3'b000,1'b0, 0, 0, 0, 0, 0, 1'b0,1'b0,1'b0};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].pv, tbl[i].sof, tbl[i].r);
            compare($sformatf("table[%0d]", i), actual(),
                    pack(tbl[i].we, tbl[i].sh, tbl[i].wr, tbl[i].rd, tbl[i].col, tbl[i].row,
                         tbl[i].st, tbl[i].win, tbl[i].ld, tbl[i].fd));
        end

        // Contiguous frame: interior window count and a single frame_done.
        step(1'b0, 1'b0, 1'b1);
        win_cnt = 0; fd_cnt = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < W * H; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_int("frame1_win_count", win_cnt, (H - 2) * (W - 2));
        check_int("frame1_frame_done", fd_cnt, 1);
        check_int("frame1_end_state", int'(bus.state), 0);

        // Same frame with pix_valid toggling.
        win_cnt = 0; fd_cnt = 0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 1; i < W * H; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check_int("frame2_win_count", win_cnt, (H - 2) * (W - 2));
        check_int("frame2_frame_done", fd_cnt, 1);

        // Mid-frame resync at (3,4), then two more lines without interior windows.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 3 * W + 4; i++) step(1'b1, 1'b0, 1'b0);
        win_cnt = 0; fd_cnt = 0;
        step(1'b1, 1'b1, 1'b0);
        check_int("resync_state", int'(bus.state), 1);
        check_int("resync_col", int'(bus.col), 0);
        check_int("resync_row", int'(bus.row), 0);
        for (int i = 1; i < 2 * W; i++) step(1'b1, 1'b0, 1'b0);
        check_int("resync_win_count", win_cnt, 0);
        check_int("resync_frame_done", fd_cnt, 0);

        // Reset during RUN, then pixels without sof are ignored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        check_int("pre_rst_state", int'(bus.state), 2);
        step(1'b1, 1'b0, 1'b1);
        check_int("rst_outputs", int'(actual()), 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        check_int("ignored_state", int'(bus.state), 0);

        // sof on the last pixel of a frame.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < W * H - 1; i++) step(1'b1, 1'b0, 1'b0);
        fd_cnt = 0;
        step(1'b1, 1'b1, 1'b0);
        check_int("sof_last_fd", fd_cnt, 0);
        check_int("sof_last_state", int'(bus.state), 1);
        check_int("sof_last_pos", int'(bus.col) + int'(bus.row), 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 149) == 0),
                 1'($urandom_range(0, 499) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end
endmodule
